// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and sequencer state encoding for the MIPS memory path
package mips_pkg;
    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_DATA_W = 32;
    localparam int SEQ_MAX_WAIT = 255;
    typedef enum logic [2:0] {
        SEQ_RESET,
        SEQ_FETCH,
        SEQ_EXEC,
        SEQ_DATA,
        SEQ_COMMIT,
        SEQ_HALT
    } seq_state_t;
endpackage

// File: rtl/mips_mem_sequencer_if.sv
// mips_mem_sequencer_if: shared variable-latency memory port
interface mips_mem_sequencer_if #(
    parameter int ADDR_W = mips_pkg::MIPS_ADDR_W,
    parameter int DATA_W = mips_pkg::MIPS_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    modport master(output req, we, addr, wdata, input ack, rdata);
    modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: flags the cycle in which a request has gone MAX_WAIT cycles unacknowledged
module mem_wait_timer #(
    parameter int MAX_WAIT = mips_pkg::SEQ_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(MAX_WAIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    // the current waiting cycle is the MAX_WAIT-th one
    assign expired = en && cnt == W'(MAX_WAIT - 1);
endmodule

// File: rtl/mips_mem_sequencer.sv
// mips_mem_sequencer: serialises fetch and load/store onto one memory port and stalls the core
module mips_mem_sequencer
    import mips_pkg::*;
#(
    parameter int ADDR_W = MIPS_ADDR_W,
    parameter int DATA_W = MIPS_DATA_W,
    parameter int MAX_WAIT = SEQ_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    core_pc,
    input  logic [ADDR_W-1:0]    core_alu_out,
    input  logic [DATA_W-1:0]    core_write_data,
    input  logic                 core_mem_write,
    input  logic                 core_mem_read,
    output logic [DATA_W-1:0]    core_instr,
    output logic [DATA_W-1:0]    core_read_data,
    output logic                 core_stall,
    mips_mem_sequencer_if.master mem,
    output logic                 bus_err,
    output logic [31:0]          retired
);
    seq_state_t state, state_n;
    logic mem_op, ack, commit, expired;
    assign mem_op = core_mem_read || core_mem_write;
    assign ack = mem.req && mem.ack;
    assign commit = state == SEQ_COMMIT || (state == SEQ_EXEC && !mem_op);
    assign core_stall = !commit;
    always_comb begin
        state_n = state;
        mem.req = 1'b0;
        mem.we = 1'b0;
        mem.addr = '0;
        mem.wdata = '0;
        case (state)
            SEQ_RESET: state_n = SEQ_FETCH;
            SEQ_FETCH: begin
                mem.req = 1'b1;
                mem.addr = core_pc;
                state_n = ack ? SEQ_EXEC : expired ? SEQ_HALT : SEQ_FETCH;
            end
            SEQ_EXEC: state_n = mem_op ? SEQ_DATA : SEQ_FETCH;
            SEQ_DATA: begin
                mem.req = 1'b1;
                mem.we = core_mem_write;
                mem.addr = core_alu_out;
                mem.wdata = core_write_data;
                state_n = ack ? SEQ_COMMIT : expired ? SEQ_HALT : SEQ_DATA;
            end
            SEQ_COMMIT: state_n = SEQ_FETCH;
            default: state_n = SEQ_HALT;
        endcase
    end
    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(mem.ack || state_n != state),
        .en(mem.req && !mem.ack),
        .expired(expired)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state <= SEQ_RESET;
            core_instr <= '0;
            core_read_data <= '0;
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_n;
            if (state == SEQ_FETCH && ack) core_instr <= mem.rdata;
            // a combined read+write decodes as a store, so the load register is left alone
            if (state == SEQ_DATA && ack && core_mem_read && !core_mem_write) core_read_data <= mem.rdata;
            if (expired) bus_err <= 1'b1;
            if (commit) retired <= retired + 32'd1;
        end
endmodule

// File: tb/tb_mips_mem_sequencer.sv
// tb_mips_mem_sequencer: directed cycle-by-cycle checks of the memory sequencer
module tb_mips_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_pc, core_alu_out, core_write_data;
    logic        core_mem_write, core_mem_read;
    logic [31:0] core_instr, core_read_data, retired;
    logic        core_stall, bus_err;
    int passed = 0;
    int total = 0;

    mips_mem_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips_mem_sequencer #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .core_pc(core_pc),
        .core_alu_out(core_alu_out),
        .core_write_data(core_write_data),
        .core_mem_write(core_mem_write),
        .core_mem_read(core_mem_read),
        .core_instr(core_instr),
        .core_read_data(core_read_data),
        .core_stall(core_stall),
        .mem(bus),
        .bus_err(bus_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        core_pc = '0;
        core_alu_out = '0;
        core_write_data = '0;
        core_mem_write = 1'b0;
        core_mem_read = 1'b0;
        bus.ack = 1'b0;
        bus.rdata = '0;
        step();
        step();
        #1;
        check("rst_stall", core_stall, 1);
        check("rst_req", bus.req, 0);
        check("rst_we", bus.we, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_instr", core_instr, 0);
        check("rst_rdata", core_read_data, 0);
        check("rst_retired", retired, 0);
        check("rst_buserr", bus_err, 0);
        rst = 1'b0;
        #1 check("reset_state_req", bus.req, 0);
        // add at PC 0, zero-wait
        step();
        core_pc = 32'd0;
        bus.ack = 1'b1;
        bus.rdata = 32'h00221820;
        #1;
        check("add_fetch_req", bus.req, 1);
        check("add_fetch_addr", bus.addr, 0);
        check("add_fetch_we", bus.we, 0);
        check("add_fetch_stall", core_stall, 1);
        step();
        bus.ack = 1'b0;
        #1;
        check("add_exec_instr", core_instr, 32'h00221820);
        check("add_exec_stall", core_stall, 0);
        check("add_exec_req", bus.req, 0);
        // load: fetch zero-wait, data ack after two wait cycles
        step();
        core_pc = 32'd4;
        bus.ack = 1'b1;
        bus.rdata = 32'h8C020008;
        #1;
        check("fetch2_addr", bus.addr, 4);
        check("fetch2_req", bus.req, 1);
        check("add_retired", retired, 1);
        check("fetch2_stall", core_stall, 1);
        step();
        bus.ack = 1'b0;
        core_mem_read = 1'b1;
        core_alu_out = 32'h100;
        #1;
        check("ld_exec_instr", core_instr, 32'h8C020008);
        check("ld_exec_stall", core_stall, 1);
        check("ld_exec_req", bus.req, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            check("ld_wait_req", bus.req, 1);
            check("ld_wait_addr", bus.addr, 32'h100);
            check("ld_wait_we", bus.we, 0);
            check("ld_wait_stall", core_stall, 1);
        end
        step();
        bus.ack = 1'b1;
        bus.rdata = 32'hDEADBEEF;
        #1 check("ld_ack_req", bus.req, 1);
        step();
        bus.ack = 1'b0;
        #1;
        check("ld_commit_rdata", core_read_data, 32'hDEADBEEF);
        check("ld_commit_stall", core_stall, 0);
        check("ld_commit_req", bus.req, 0);
        check("ld_commit_retired", retired, 1);
        // store with read also high: acts as store
        step();
        core_mem_read = 1'b0;
        core_pc = 32'd8;
        bus.ack = 1'b1;
        bus.rdata = 32'hAC030010;
        #1 check("ld_retired", retired, 2);
        step();
        bus.ack = 1'b0;
        core_mem_write = 1'b1;
        core_mem_read = 1'b1;
        core_write_data = 32'h12345678;
        core_alu_out = 32'h200;
        #1 check("st_exec_stall", core_stall, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            check("st_data_we", bus.we, 1);
            check("st_data_wdata", bus.wdata, 32'h12345678);
            check("st_data_addr", bus.addr, 32'h200);
            check("st_data_req", bus.req, 1);
        end
        bus.ack = 1'b1;
        bus.rdata = 32'hCAFEF00D;
        step();
        bus.ack = 1'b0;
        #1;
        check("st_commit_rdata", core_read_data, 32'hDEADBEEF);
        check("st_commit_stall", core_stall, 0);
        check("st_commit_we", bus.we, 0);
        // retired wrap and stray ack during EXEC
        step();
        core_mem_write = 1'b0;
        core_mem_read = 1'b0;
        core_pc = 32'd12;
        #1 check("st_retired", retired, 3);
        force dut.retired = 32'hFFFFFFFF;
        #1 release dut.retired;
        step();
        #1 check("wrap_preload", retired, 32'hFFFFFFFF);
        bus.ack = 1'b1;
        bus.rdata = 32'h00221820;
        step();
        bus.rdata = 32'h55555555;
        #1 check("stray_exec_stall", core_stall, 0);
        step();
        bus.ack = 1'b0;
        #1;
        check("stray_instr", core_instr, 32'h00221820);
        check("wrap_retired", retired, 0);
        // reset during a DATA wait cycle, ack arrives one cycle late
        core_pc = 32'd16;
        bus.ack = 1'b1;
        bus.rdata = 32'h8C020008;
        step();
        bus.ack = 1'b0;
        core_mem_read = 1'b1;
        core_alu_out = 32'h300;
        step();
        #1 check("rstmid_data_req", bus.req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ack = 1'b1;
        bus.rdata = 32'h99999999;
        #1;
        check("rstmid_req", bus.req, 0);
        check("rstmid_rdata", core_read_data, 0);
        check("rstmid_retired", retired, 0);
        check("rstmid_stall", core_stall, 1);
        step();
        bus.ack = 1'b0;
        core_mem_read = 1'b0;
        core_pc = 32'h40;
        #1;
        check("rstmid_refetch_req", bus.req, 1);
        check("rstmid_refetch_addr", bus.addr, 32'h40);
        check("rstmid_late_ack_rdata", core_read_data, 0);
        check("rstmid_late_ack_instr", core_instr, 0);
        // timeout: mem_req rose this cycle, never acked
        for (int i = 1; i < 4; i++) begin
            step();
            #1;
            check("to_wait_req", bus.req, 1);
            check("to_wait_err", bus_err, 0);
        end
        step();
        #1;
        check("to_err", bus_err, 1);
        check("to_req", bus.req, 0);
        check("to_stall", core_stall, 1);
        bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("halt_req", bus.req, 0);
            check("halt_stall", core_stall, 1);
            check("halt_err", bus_err, 1);
            check("halt_instr", core_instr, 0);
        end
        bus.ack = 1'b0;
        rst = 1'b1;
        step();
        #1;
        check("halt_rst_err", bus_err, 0);
        check("halt_rst_stall", core_stall, 1);
        rst = 1'b0;
        step();
        #1;
        check("halt_rst_refetch", bus.req, 1);
        check("halt_rst_addr", bus.addr, 32'h40);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_mem_sequencer.md
# mips_mem_sequencer

Multi-cycle access sequencer placed between `mips_main` and a single shared, variable-latency memory port. It serialises instruction fetch and data load/store onto that one port, and holds the fetched instruction and loaded data in registers. It drives a stall that the core uses to gate PC update and register write. It also retires instructions, counts them, and flags a hung memory through a wait timeout.

## Interface
Parameters:
- `ADDR_W`, default 32: memory address width.
- `DATA_W`, default 32: memory data width.
- `MAX_WAIT`, default 255: maximum cycles `mem_req` may stay high without `mem_ack` before a bus error.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `core_pc` in ADDR_W: fetch address from the core.
- `core_alu_out` in ADDR_W: data address from the core.
- `core_write_data` in DATA_W: store data from the core.
- `core_mem_write` in 1: decoded store.
- `core_mem_read` in 1: decoded load.
- `core_instr` out DATA_W: registered instruction fed to the core.
- `core_read_data` out DATA_W: registered load data fed to the core.
- `core_stall` out 1: high means the core must not update PC or the register file.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: write data.
- `mem_ack` in 1: one-cycle completion pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_W: memory read data.
- `bus_err` out 1: sticky timeout flag.
- `retired` out 32: count of committed instructions.

## Operation
- States:
  - RESET: entered while `rst` is high.
  - FETCH
  - EXEC
  - DATA
  - COMMIT
  - HALT
- RESET → FETCH on the first cycle after `rst` falls.
- FETCH:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=`core_pc`.
  - On `mem_ack`: load `core_instr` ← `mem_rdata` and go to EXEC.
- EXEC: the core decodes the registered `core_instr`.
  - `core_mem_read` or `core_mem_write` high → DATA.
  - Otherwise this cycle is the commit cycle: `core_stall`=0, `retired`+1, next state FETCH.
- DATA:
  - Drive `mem_req`=1, `mem_addr`=`core_alu_out`, `mem_we`=`core_mem_write`, `mem_wdata`=`core_write_data`.
  - On `mem_ack`: if load, `core_read_data` ← `mem_rdata`. Go to COMMIT.
- COMMIT: `core_stall`=0, `retired`+1, next state FETCH.
- `core_mem_read` and `core_mem_write` both high in EXEC: treated as a store. `core_read_data` is unchanged.
- Wait timer:
  - Counts the cycles `mem_req` is high without `mem_ack`.
  - Clears on `mem_ack` and on every state change.
  - When the count reaches `MAX_WAIT` with no ack: `bus_err` ← 1, go to HALT.
- HALT: `mem_req`=0, `core_stall`=1. Only `rst` exits.
- `retired` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - `core_instr` = 0, `core_read_data` = 0, `retired` = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `bus_err` = 0.
  - `core_stall` = 1.
- `core_stall` is 0 in exactly one cycle per instruction (EXEC-commit or COMMIT). It is 1 in every other state, including RESET and HALT.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from the assertion of `mem_req` through the ack cycle.
  - `mem_req` is 0 in the cycle after the ack, because EXEC and COMMIT never request.
  - A zero-wait memory may ack in the first cycle `mem_req` is high.
- Latency with zero-wait memory:
  - ALU/branch/jump instruction: 2 cycles (FETCH, EXEC).
  - Load/store: 4 cycles (FETCH, EXEC, DATA, COMMIT).
  - Each wait cycle adds 1.
- `mem_ack` while `mem_req`=0 is ignored.
- Timeout: with `MAX_WAIT`=N and no ack, `bus_err` rises N cycles after `mem_req` rises, and `mem_req` is 0 from the following cycle.
- `rst` mid-request: `mem_req` is 0 in the cycle after `rst` is sampled. No registered output reflects a late ack. The memory side tolerates abandoned requests.

## Structure
- Shared package `mips_pkg`:
  - State enum: `SEQ_RESET`, `SEQ_FETCH`, `SEQ_EXEC`, `SEQ_DATA`, `SEQ_COMMIT`, `SEQ_HALT`.
  - Default `MAX_WAIT`.
  - `ADDR_W`/`DATA_W` constants.
- One sub-module, `mem_wait_timer`:
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Output: `expired`.
  - Parameterised by `MAX_WAIT`; counter width is $clog2(MAX_WAIT+1).
- The FSM and output registers live in the top module. `mips_main` gains a stall input that gates PC and register-file writes.

## Test plan
- Zero-wait memory; `core_instr` 0x00221820 (add, no mem) at PC 0 → `core_stall` low only in cycle 2; `retired`=1; second fetch at `core_pc` 4 in cycle 3.
- Load 0x8C020008 with a 2-cycle ack delay, `mem_rdata`=0xDEADBEEF → DATA `mem_addr`=`core_alu_out`, `mem_we`=0; `core_read_data`=0xDEADBEEF in COMMIT; 6 cycles total.
- Store with `core_write_data`=0x12345678 → in DATA `mem_we`=1 and `mem_wdata`=0x12345678, both stable until ack; `core_read_data` unchanged.
- `MAX_WAIT`=4, never ack → `bus_err`=1 four cycles after `mem_req` rises; then `mem_req`=0 and `core_stall`=1 forever; `rst` clears both.
- Assert `rst` in a DATA wait cycle, then ack one cycle later → `mem_req`=0 the next cycle; `core_read_data`=0, `retired`=0; fetch restarts from `core_pc`.
- Stray `mem_ack` during EXEC, plus `retired` preloaded to 0xFFFFFFFF via a forced value → ack ignored; `retired` wraps to 0 on the next commit.
